// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, FSM state type and control-vector layout for the pipeline controller.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;
  localparam logic [3:0] S_BUB = 4'h8;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic m_stall;
    logic w_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic set_cc;
  } ctrl_t;

  // Every stage register holds its value; nothing is squashed and CCs are untouched.
  localparam ctrl_t CTRL_FROZEN = '{f_stall: 1'b1, d_stall: 1'b1, e_stall: 1'b1,
                                    m_stall: 1'b1, w_stall: 1'b1, d_bubble: 1'b0,
                                    e_bubble: 1'b0, m_bubble: 1'b0, set_cc: 1'b0};

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational hazard terms and the pipeline control vector used when the core advances.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] M_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic [3:0] E_dstM_i,
  input  logic       e_Cnd_i,
  input  logic [3:0] m_stat_i,
  input  logic [3:0] W_stat_i,
  output logic       lu_o,
  output logic       mp_o,
  output logic       wx_o,
  output ctrl_t      ctrl_o
);

  logic ret;
  logic mx;

  always_comb begin
    lu_o = ((E_icode_i == I_MRMOV) || (E_icode_i == I_POP)) && (E_dstM_i != RNONE) &&
           ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret  = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
    mp_o = (E_icode_i == I_JXX) && !e_Cnd_i;
    mx   = is_exc(m_stat_i);
    wx_o = is_exc(W_stat_i);
  end

  // A load-use stall takes precedence over the ret bubble in decode.
  always_comb begin
    ctrl_o          = '0;
    ctrl_o.f_stall  = lu_o || ret;
    ctrl_o.d_stall  = lu_o;
    ctrl_o.w_stall  = wx_o;
    ctrl_o.d_bubble = mp_o || (ret && !lu_o);
    ctrl_o.e_bubble = mp_o || lu_o;
    ctrl_o.m_bubble = mx || wx_o;
    ctrl_o.set_cc   = (E_icode_i == I_OPQ) && !mx && !wx_o;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: run/pause/step/halt FSM, freeze muxing of hazard controls, saturating perf counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause_req,
  input  logic             step_req,
  output logic             step_ack,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [3:0]       halt_stat,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [3:0]       halt_stat_q, halt_stat_d;
  logic             step_ack_q, step_ack_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, lu_q, lu_d, mp_q, mp_d;

  logic  lu, mp, wx, adv, retire;
  ctrl_t raw_ctrl, ctrl;

  hazard_detect u_hazard (
    .D_icode_i (D_icode),
    .E_icode_i (E_icode),
    .M_icode_i (M_icode),
    .d_srcA_i  (d_srcA),
    .d_srcB_i  (d_srcB),
    .E_dstM_i  (E_dstM),
    .e_Cnd_i   (e_Cnd),
    .m_stat_i  (m_stat),
    .W_stat_i  (W_stat),
    .lu_o      (lu),
    .mp_o      (mp),
    .wx_o      (wx),
    .ctrl_o    (raw_ctrl)
  );

  // W_icode is not needed: retirement is judged from W_stat alone.
  logic unused_w_icode;
  assign unused_w_icode = ^W_icode;

  assign adv    = (state_q == ST_RUN) || ((state_q == ST_PAUSE) && step_req);
  assign retire = (W_stat == S_AOK) || (W_stat == S_HLT);
  assign ctrl   = adv ? raw_ctrl : CTRL_FROZEN;

  assign F_stall  = ctrl.f_stall;
  assign D_stall  = ctrl.d_stall;
  assign E_stall  = ctrl.e_stall;
  assign M_stall  = ctrl.m_stall;
  assign W_stall  = ctrl.w_stall;
  assign D_bubble = ctrl.d_bubble;
  assign E_bubble = ctrl.e_bubble;
  assign M_bubble = ctrl.m_bubble;
  assign set_cc   = ctrl.set_cc;

  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    halt_stat_d = halt_stat_q;
    step_ack_d  = (state_q == ST_PAUSE) && step_req;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (wx) state_d = ST_HALTED;
                 else if (pause_req) state_d = ST_PAUSE;
      ST_PAUSE:  if (start) state_d = ST_RUN;
                 else if (step_req && wx) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    if ((state_d == ST_HALTED) && (state_q != ST_HALTED)) begin
      halted_d    = 1'b1;
      halt_stat_d = W_stat;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    lu_d  = lu_q;
    mp_d  = mp_q;
    if (adv) begin
      if (cyc_q != '1)           cyc_d = cyc_q + CNT_W'(1);
      if (retire && ret_q != '1) ret_d = ret_q + CNT_W'(1);
      if (lu && lu_q != '1)      lu_d  = lu_q + CNT_W'(1);
      if (mp && mp_q != '1)      mp_d  = mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      halted_q    <= 1'b0;
      halt_stat_q <= 4'h0;
      step_ack_q  <= 1'b0;
      cyc_q       <= '0;
      ret_q       <= '0;
      lu_q        <= '0;
      mp_q        <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      halt_stat_q <= halt_stat_d;
      step_ack_q  <= step_ack_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      lu_q        <= lu_d;
      mp_q        <= mp_d;
    end
  end

  assign state     = state_q;
  assign halted    = halted_q;
  assign halt_stat = halt_stat_q;
  assign step_ack  = step_ack_q;
  assign cyc_cnt   = cyc_q;
  assign ret_cnt   = ret_q;
  assign lu_cnt    = lu_q;
  assign mp_cnt    = mp_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl, plus a 4-bit-counter instance for saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, pause_req, step_req, e_Cnd;
  logic [3:0]  D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM, m_stat, W_stat;
  logic        step_ack, set_cc, halted;
  logic [4:0]  stl;
  logic [2:0]  bub;
  logic [3:0]  halt_stat;
  logic [1:0]  state;
  logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

  logic        s_rst_n, s_start, s_step_ack, s_set_cc, s_halted;
  logic [4:0]  s_stl;
  logic [2:0]  s_bub;
  logic [3:0]  s_halt_stat;
  logic [1:0]  s_state;
  logic [3:0]  s_cyc, s_ret, s_lu, s_mp;

  int total = 0;
  int bad   = 0;
  int exp_cyc = 0;
  int acks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause_req(pause_req), .step_req(step_req),
    .step_ack(step_ack), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(stl[4]), .D_stall(stl[3]), .E_stall(stl[2]), .M_stall(stl[1]), .W_stall(stl[0]),
    .D_bubble(bub[2]), .E_bubble(bub[1]), .M_bubble(bub[0]), .set_cc(set_cc),
    .halted(halted), .halt_stat(halt_stat), .state(state),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .pause_req(1'b0), .step_req(1'b0),
    .step_ack(s_step_ack), .D_icode(4'h1), .E_icode(4'h1), .M_icode(4'h1),
    .W_icode(4'h1), .d_srcA(4'hF), .d_srcB(4'hF), .E_dstM(4'hF), .e_Cnd(1'b1),
    .m_stat(4'h1), .W_stat(4'h1),
    .F_stall(s_stl[4]), .D_stall(s_stl[3]), .E_stall(s_stl[2]), .M_stall(s_stl[1]),
    .W_stall(s_stl[0]), .D_bubble(s_bub[2]), .E_bubble(s_bub[1]), .M_bubble(s_bub[0]),
    .set_cc(s_set_cc), .halted(s_halted), .halt_stat(s_halt_stat), .state(s_state),
    .cyc_cnt(s_cyc), .ret_cnt(s_ret), .lu_cnt(s_lu), .mp_cnt(s_mp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; pause_req = 1'b0; step_req = 1'b0; e_Cnd = 1'b1;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; m_stat = 4'h8; W_stat = 4'h8;
  endtask

  initial begin
    rst_n = 1'b0; s_rst_n = 1'b0; s_start = 1'b0;
    idle_inputs();
    tick(); tick();
    chk("rst_frz_stall", 64'(stl), 64'h1F);
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_halted", 64'({halted, halt_stat}), 64'h0);
    chk("rst_cnts", 64'(cyc_cnt | ret_cnt | lu_cnt | mp_cnt), 64'd0);
    chk("rst_ack", 64'(step_ack), 64'd0);
    chk("idle_frz", 64'({stl, bub, set_cc}), 64'({5'b11111, 3'b000, 1'b0}));

    start = 1'b1; tick(); start = 1'b0;
    chk("start_run", 64'(state), 64'd1);

    // load-use on srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    chk("lu_stl", 64'(stl), 64'b11000);
    chk("lu_bub", 64'(bub), 64'b010);
    chk("lu_cnt0", 64'(lu_cnt), 64'd0);
    tick(); exp_cyc++; idle_inputs();
    chk("lu_cnt1", 64'(lu_cnt), 64'd1);

    E_icode = 4'h6; #1;
    chk("setcc", 64'({stl, bub, set_cc}), 64'({5'b00000, 3'b000, 1'b1}));
    tick(); exp_cyc++;
    E_icode = 4'h6; m_stat = 4'h3; #1;
    chk("mx_setcc", 64'({stl, bub, set_cc}), 64'({5'b00000, 3'b001, 1'b0}));
    tick(); exp_cyc++; idle_inputs();
    chk("mx_state", 64'(state), 64'd1);

    // mispredict together with ret in decode
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9; #1;
    chk("mpret_stl", 64'(stl), 64'b10000);
    chk("mpret_bub", 64'(bub), 64'b110);
    tick(); exp_cyc++; idle_inputs();
    chk("mp_cnt", 64'(mp_cnt), 64'd1);

    // ret plus load-use on srcB: stall wins over the decode bubble
    D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2; #1;
    chk("retlu", 64'({stl, bub}), 64'({5'b11000, 3'b010}));
    tick(); exp_cyc++; idle_inputs();

    // E_dstM=RNONE never matches, even against RNONE sources; step_req in RUN is ignored
    E_icode = 4'h5; step_req = 1'b1; #1;
    chk("lu_none", 64'({stl, bub}), 64'd0);
    tick(); exp_cyc++; idle_inputs();
    chk("lu_none_cnt", 64'(lu_cnt), 64'd2);
    chk("run_no_ack", 64'(step_ack), 64'd0);

    pause_req = 1'b1; tick(); exp_cyc++; idle_inputs();
    chk("pause_state", 64'(state), 64'd2);
    E_icode = 4'h6; #1;
    chk("pause_frz", 64'({stl, bub, set_cc}), 64'({5'b11111, 3'b000, 1'b0}));
    tick(); idle_inputs();
    chk("pause_cyc", 64'(cyc_cnt), 64'(exp_cyc));

    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1; #1;
      chk("step_adv", 64'(stl), 64'd0);
      tick(); exp_cyc++; step_req = 1'b0;
      if (step_ack) acks++;
      #1;
      chk("step_gap_frz", 64'(stl), 64'h1F);
      tick();
      chk("step_ack_low", 64'(step_ack), 64'd0);
    end
    chk("step_acks", 64'(acks), 64'd3);
    chk("step_cyc", 64'(cyc_cnt), 64'(exp_cyc));

    step_req = 1'b1; tick(); exp_cyc++;
    chk("b2b_ack1", 64'(step_ack), 64'd1);
    tick(); exp_cyc++; step_req = 1'b0;
    chk("b2b_ack2", 64'(step_ack), 64'd1);
    tick();
    chk("b2b_cyc", 64'({step_ack, cyc_cnt}), 64'({1'b0, 32'(exp_cyc)}));

    start = 1'b1; step_req = 1'b1; tick(); exp_cyc++; idle_inputs();
    chk("resume", 64'(state), 64'd1);

    while (exp_cyc < 57) begin
      tick(); exp_cyc++;
    end
    chk("cyc57", 64'(cyc_cnt), 64'd57);
    rst_n = 1'b0; #1;
    chk("arst_cyc", 64'(cyc_cnt), 64'd0);
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_stl", 64'({stl, bub}), 64'({5'b11111, 3'b000}));
    chk("arst_cnts", 64'(lu_cnt | mp_cnt), 64'd0);
    tick(); rst_n = 1'b1;

    start = 1'b1; tick(); idle_inputs();
    W_stat = 4'h1; tick();
    // halt retires while a pause request arrives in the same cycle
    W_stat = 4'h2; pause_req = 1'b1; E_icode = 4'h6; #1;
    chk("halt_stl", 64'({stl, bub, set_cc}), 64'({5'b00001, 3'b001, 1'b0}));
    tick(); idle_inputs();
    chk("halt_state", 64'(state), 64'd3);
    chk("halt_latch", 64'({halted, halt_stat}), 64'h12);
    chk("halt_cnts", 64'({ret_cnt, cyc_cnt}), 64'({32'd2, 32'd2}));
    start = 1'b1; step_req = 1'b1; W_stat = 4'h3; tick(); idle_inputs();
    chk("halt_abs", 64'({state, halted, halt_stat, step_ack}), 64'({2'd3, 1'b1, 4'h2, 1'b0}));
    chk("halt_frz", 64'({stl, cyc_cnt}), 64'({5'b11111, 32'd2}));

    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 64'({s_cyc, s_stl, s_bub, s_set_cc}), 64'({4'd14, 9'd0}));
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cyc", 64'({s_cyc, s_ret}), 64'({4'd15, 4'd15}));
    chk("sat_misc", 64'({s_state, s_halted, s_halt_stat, s_step_ack, s_lu, s_mp}),
        64'({2'd1, 14'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 processor. It observes the F/D/E/M/W pipeline-register fields and the decode/execute/memory combinational signals. It drives stall and bubble for every pipeline register, plus the condition-code write enable. It adds a run/pause/single-step/halt state machine and saturating performance counters, so the testbench and debug logic can start, freeze, step and inspect the core.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: pulse. IDLE→RUN, or PAUSE→RUN.
- `pause_req` input 1: pulse. RUN→PAUSE.
- `step_req` input 1: pulse. Advances the pipeline exactly one cycle while in PAUSE.
- `step_ack` output 1: one-cycle pulse in the cycle after an accepted step.
- `D_icode`, `E_icode`, `M_icode`, `W_icode` input 4: icode held in each stage register.
- `d_srcA`, `d_srcB` input 4: decode source register IDs; 4'hF means none.
- `E_dstM` input 4: load destination register in E.
- `e_Cnd` input 1: branch condition computed in execute.
- `m_stat`, `W_stat` input 4: status codes.
- `F_stall`, `D_stall`, `E_stall`, `M_stall`, `W_stall` output 1: hold the stage register.
- `D_bubble`, `E_bubble`, `M_bubble` output 1: load a nop into the stage register. The loaded nop has stat 4'h8 and all reg IDs 4'hF.
- `set_cc` output 1: condition-code write enable.
- `halted` output 1: core is stopped permanently.
- `halt_stat` output 4: the W_stat that caused the halt.
- `state` output 2: current FSM state.
- `cyc_cnt`, `ret_cnt`, `lu_cnt`, `mp_cnt` output CNT_W: counts of advance cycles, retired instructions, load-use stalls and mispredicts.

## Operation
- Encodings:
  - icode: 0 halt, 1 nop, 2 cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 opq, 7 jXX, 8 call, 9 ret, A push, B pop.
  - stat: 1 AOK, 2 HLT, 3 ADR, 4 INS, 8 BUB.
  - Exception means stat ∈ {2, 3, 4}.
- Hazard terms, all combinational:
  - `lu` = E_icode∈{5,B} ∧ E_dstM≠F ∧ E_dstM∈{d_srcA,d_srcB}.
  - `ret` = 9∈{D_icode, E_icode, M_icode}.
  - `mp` = E_icode=7 ∧ !e_Cnd.
  - `mx` = m_stat exception.
  - `wx` = W_stat exception.
- Advance cycle: state RUN, or state PAUSE with step_req=1. In an advance cycle:
  - F_stall = lu ∨ ret.
  - D_stall = lu.
  - D_bubble = mp ∨ (ret ∧ !lu).
  - E_bubble = mp ∨ lu.
  - M_bubble = mx ∨ wx.
  - W_stall = wx.
  - E_stall = M_stall = 0.
  - set_cc = E_icode=6 ∧ !mx ∧ !wx.
- Frozen cycle (every other cycle):
  - All five stalls = 1, all bubbles = 0, set_cc = 0.
  - Writeback still re-writes the held W values; this is idempotent.
- FSM states: IDLE=0, RUN=1, PAUSE=2, HALTED=3.
  - IDLE: start→RUN.
  - RUN: wx→HALTED; otherwise pause_req→PAUSE.
  - PAUSE: start→RUN (start has priority over step_req). step_req with wx→HALTED.
  - HALTED: absorbing; only rst_n exits.
- On entering HALTED: latch halted=1 and halt_stat=W_stat.
- Counters saturate at all-ones and update only in advance cycles:
  - `cyc_cnt`: +1 every advance cycle.
  - `ret_cnt`: +1 when W_stat∈{1,2} (AOK or HLT; the halt instruction counts as retired).
  - `lu_cnt`: +1 when lu.
  - `mp_cnt`: +1 when mp.

## Timing
- Reset values: state=IDLE, halted=0, halt_stat=4'h0, all counters 0, step_ack=0.
  - Stall/bubble outputs in IDLE after reset: frozen pattern.
- Stall, bubble and set_cc are combinational from current state and inputs. They have zero latency and are consumed at the same clk edge.
- State, counters, halted and step_ack are registered. A state transition takes effect on the edge following the triggering input.
- step_ack rises one cycle after the step_req edge and lasts exactly 1 cycle.
  - step_req outside PAUSE is ignored and produces no ack.
  - Back-to-back step_req pulses each advance one cycle and each produce one ack.
- pause_req and wx in the same RUN cycle: go to HALTED.
- rst_n asserted mid-operation: all registered outputs clear immediately (asynchronous), the FSM returns to IDLE, and outputs are frozen while rst_n is low.

## Structure
- Shared package `y86_pkg`: icode constants, stat constants, RNONE=4'hF, FSM state enum, `is_exc()` function.
- Sub-module `hazard_detect`: purely combinational. Produces lu/ret/mp/mx/wx and the raw advance-cycle control vector.
- `pipe_ctrl` top: FSM, freeze muxing, counters.

## Test plan
- Load-use: in RUN, E_icode=5, E_dstM=3, d_srcA=3. Required: F_stall=D_stall=E_bubble=1, D_bubble=0, lu_cnt 0→1.
- Mispredict plus ret together: E_icode=7, e_Cnd=0, D_icode=9. Required: D_bubble=E_bubble=1, F_stall=1, mp_cnt +1.
- Halt retire: W_stat=2 in RUN. Required: W_stall=1, M_bubble=1, ret_cnt +1. Next cycle state=3, halted=1, halt_stat=2. A later start leaves the state unchanged.
- Pause/step: pause_req, then 3 step_req pulses spaced 2 cycles apart. Required: 3 step_ack pulses, cyc_cnt +3, all stalls=1 between steps.
- Reset mid-run: drop rst_n with cyc_cnt=57. Required: cyc_cnt=0, state=0, stalls=1 immediately, without waiting for a clk edge.
- Saturation: with CNT_W=4, run for 20 cycles. Required: cyc_cnt holds at 15.
